// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the HI/LO
// multiply/divide unit.
//   start/op/src_a/src_b : issue MULT/MULTU/DIV/DIVU with latched operands
//   hilo_wr/wr_data      : MTHI (bit1) / MTLO (bit0) writes while idle
//   flush                : cancel the in-flight operation
//   busy/done/div_by_zero: status back to the hazard logic
//   hi/lo                : architectural HI/LO registers for MFHI/MFLO
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [1:0]       hilo_wr;
    logic [WIDTH-1:0] wr_data;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hilo_wr, wr_data, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hilo_wr, wr_data, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (MIPS execute stage).
//   clk   : core clock
//   n_rst : asynchronous active-low reset
//   bus   : muldiv_unit_if slave port (issue, MTHI/MTLO, flush, status, HI/LO)
// Signed operations run on magnitudes; the sign fix-up and the single
// HI/LO write happen in FIX. Multiply is shift-add (or one combinational
// product when FAST_MUL != 0); divide is restoring, one bit per cycle.
module muldiv_unit #(
    parameter int          WIDTH    = 32,
    parameter int unsigned FAST_MUL = 0
) (
    input  logic          clk,
    input  logic          n_rst,
    muldiv_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz_out;

    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic               w_accept;
    logic               w_hilo_en;
    logic               w_fix_wr;
    logic               w_last;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;

    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Operand magnitudes (op[0]=0 selects the signed variants)
    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.src_a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.src_b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_abs_b  = w_b_neg ? -bus.src_b : bus.src_b;

    generate
        if (FAST_MUL != 0) begin : g_fast
            assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
        end else begin : g_iter
            assign w_fast_prod = '0;
        end
    endgenerate

    // Flush in IDLE masks both start and hilo_wr; start beats hilo_wr
    assign w_accept  = (r_state == ST_IDLE) && bus.start && !bus.flush;
    assign w_hilo_en = (r_state == ST_IDLE) && !bus.start && !bus.flush;
    assign w_fix_wr  = (r_state == ST_FIX) && !bus.flush;
    assign w_last    = (r_cnt == '0);

    // Shift-add: acc = {partial product, remaining multiplier bits}
    assign w_addend   = r_acc[0] ? r_opb : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: acc = {partial remainder, dividend/quotient bits}.
    // The shifted remainder needs WIDTH+1 bits; its MSB of the difference
    // is a clean borrow because remainder < divisor.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    // Sign correction. A zero divisor leaves the dividend magnitude as the
    // remainder, so the dividend-sign fix-up restores src_a in HI.
    assign w_mul_res = r_neg_lo ? -r_acc : r_acc;
    assign w_quot    = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem     = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_res_hi  = r_is_div ? w_rem : w_mul_res[2*WIDTH-1:WIDTH];
    assign w_res_lo  = r_is_div ? (r_dbz ? '1 : w_quot) : w_mul_res[WIDTH-1:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.op[1]) begin
                        w_next = ST_DIV;
                    end else if (FAST_MUL != 0) begin
                        w_next = ST_FIX;
                    end else begin
                        w_next = ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_opb    <= w_abs_b;
            r_cnt    <= CW'(WIDTH - 1);
            r_is_div <= bus.op[1];
            r_dbz    <= bus.op[1] && (bus.src_b == '0);
            r_neg_lo <= w_a_neg ^ w_b_neg;
            if (bus.op[1]) begin
                r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
                r_neg_hi <= w_a_neg;
            end else begin
                r_acc    <= (FAST_MUL != 0) ? w_fast_prod : {{WIDTH{1'b0}}, w_abs_a};
                r_neg_hi <= w_a_neg ^ w_b_neg;
            end
        end else if (r_state == ST_MUL) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == ST_DIV) begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz_out <= 1'b0;
        end else begin
            r_done    <= w_fix_wr;
            r_dbz_out <= w_fix_wr & r_dbz;
            if (w_fix_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_hilo_en) begin
                if (bus.hilo_wr[1]) r_hi <= bus.wr_data;
                if (bus.hilo_wr[0]) r_lo <= bus.wr_data;
            end
        end
    end

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz_out;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core; sits beside the ALU in the execute stage.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and writes the results into HI/LO.
- Supports MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Drives `busy` so the hazard logic can stall issue, and accepts `flush` to cancel an in-flight operation on a pipeline squash.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be at least 4.
- FAST_MUL, 0:
  - 1 = MULT/MULTU use a single-cycle combinational product (busy for 1 cycle).
  - 0 = shift-add, one bit per cycle.

Ports:
- clk  input  1  core clock.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  issue operation in `op` (sampled at rising edge).
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- src_a  input  WIDTH  multiplicand / dividend.
- src_b  input  WIDTH  multiplier / divisor.
- hilo_wr  input  2  bit1=MTHI, bit0=MTLO.
- wr_data  input  WIDTH  data for MTHI/MTLO.
- flush  input  1  cancel in-flight operation.
- busy  output  1  operation in progress; HI/LO not valid for reads.
- done  output  1  one-cycle pulse after HI/LO take a new result.
- div_by_zero  output  1  pulses with `done` when a DIV/DIVU had src_b==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, n_rst low): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; any operation in flight is discarded.
- States:
  - IDLE: accept start or hilo_wr.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring division, one quotient bit per cycle.
  - FIX: sign correction and HI/LO write.
- Signed ops work on absolute values. The product is negated if the operand signs differ. The quotient is negated if the signs differ; the remainder takes the dividend's sign. Quotient truncates toward zero.
- Latency: start accepted at edge E.
  - busy is high from after E until edge E+WIDTH+1 (exactly WIDTH+1 cycles).
  - hi/lo update at E+WIDTH+1.
  - done and div_by_zero are high for the single cycle after that edge.
  - With FAST_MUL=1 a multiply skips MUL: busy is high 1 cycle, hi/lo update at E+1.
- Operands are latched at acceptance; later changes to src_a/src_b are ignored.
- Results: MULT/MULTU give {hi,lo} = 2*WIDTH-bit product. DIV/DIVU give lo=quotient, hi=remainder.
- Divide by zero: hi=src_a, lo=all ones, div_by_zero pulse, same latency.
- Signed overflow (most negative / -1): lo = most negative value, hi=0; no flag.
- start while busy: ignored. The pipeline must stall, and the unit does not queue.
- hilo_wr in IDLE: hi and/or lo take wr_data at the next edge.
- hilo_wr while busy: ignored.
- start and hilo_wr in the same IDLE cycle: start wins, hilo_wr ignored.
- flush while busy: return to IDLE at the next edge. hi/lo are unchanged, with no done and no div_by_zero.
- flush in IDLE: start and hilo_wr in that cycle are ignored.
- flush on the FIX edge: flush wins; no write.
- hi/lo remain stable while busy (old values visible); all updates happen on a single edge.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> busy 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses 1 cycle.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Repeat with FAST_MUL=1 -> same values, busy 1 cycle.
3. Signed divides:
   - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero stays 0.
4. DIVU 7/0 -> hi=0x00000007, lo=0xFFFFFFFF, div_by_zero and done pulse together.
5. Busy-time interactions:
   - MTHI 0x1234 in IDLE -> hi=0x1234 next cycle.
   - Start DIVU 100/3, then pulse start and hilo_wr at cycle 5 -> both ignored; result lo=33, hi=1.
   - Start MULT, assert flush at cycle 10 -> busy low next cycle, hi/lo unchanged, no done.
6. Start DIV, drop n_rst mid-operation at cycle 12 (asynchronously, between edges) -> hi=lo=0, busy=0 immediately; after release a new MULTU 6*7 gives lo=42, hi=0.
